// File: rtl/counter_seek_ctrl.sv
// Seek sequencer for a mod-9 up/down counter: pulses Up/Down along the shorter
// way around the ring until CurrentState matches the target, recovering from state 15.
module counter_seek_ctrl #(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] Target,
    input  logic       Abort,
    input  logic [3:0] CurrentState,
    output logic       Up,
    output logic       Down,
    output logic       CounterReset,
    output logic       Busy,
    output logic       Done,
    output logic       Error,
    output logic [3:0] Steps
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_STEP_UP,
        S_STEP_DN,
        S_WAIT,
        S_RECOVER,
        S_RWAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);
    localparam logic [3:0] POS_MAX      = 4'd8;

    state_t     r_state;
    logic [3:0] r_target;
    logic [3:0] r_prev;
    logic [3:0] r_timer;
    logic [3:0] r_steps;
    logic       r_up;
    logic       r_down;
    logic       r_crst;
    logic       r_busy;
    logic       r_done;
    logic       r_error;

    logic [4:0] w_diff_up;
    logic [4:0] w_diff_dn;
    logic [4:0] w_dist_up;
    logic [4:0] w_dist_dn;
    logic       w_state_bad;
    logic       w_target_bad;
    logic       w_at_target;
    logic       w_timed_out;
    logic [3:0] w_steps_inc;

    // Ring distances: a negative 5-bit difference wraps by adding the ring size.
    assign w_diff_up    = {1'b0, r_target} - {1'b0, CurrentState};
    assign w_diff_dn    = {1'b0, CurrentState} - {1'b0, r_target};
    assign w_dist_up    = w_diff_up[4] ? w_diff_up + 5'd9 : w_diff_up;
    assign w_dist_dn    = w_diff_dn[4] ? w_diff_dn + 5'd9 : w_diff_dn;
    assign w_state_bad  = (CurrentState > POS_MAX);
    assign w_target_bad = (Target > POS_MAX);
    assign w_at_target  = (CurrentState == r_target);
    assign w_timed_out  = (r_timer == TIMEOUT_LAST);
    assign w_steps_inc  = (r_steps == 4'hF) ? 4'hF : r_steps + 4'd1;

    // NOTE: state and outputs are flops updated with non-blocking assignments so
    // every branch below sees the pre-edge values of all registers.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            r_state  <= S_IDLE;
            r_target <= '0;
            r_prev   <= '0;
            r_timer  <= '0;
            r_steps  <= '0;
            r_up     <= 1'b0;
            r_down   <= 1'b0;
            r_crst   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle; a branch that wants a
            // pulse raises it for exactly the one cycle after this edge.
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_crst  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;

            if (Abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (Start) begin
                            if (w_target_bad) begin
                                r_error <= 1'b1;
                            end else begin
                                r_target <= Target;
                                r_steps  <= '0;
                                r_busy   <= 1'b1;
                                r_state  <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (w_state_bad) begin
                            r_crst  <= 1'b1;
                            r_state <= S_RECOVER;
                        end else if (w_at_target) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_dist_up <= w_dist_dn) begin
                            r_up    <= 1'b1;
                            r_steps <= w_steps_inc;
                            r_state <= S_STEP_UP;
                        end else begin
                            r_down  <= 1'b1;
                            r_steps <= w_steps_inc;
                            r_state <= S_STEP_DN;
                        end
                    end
                    S_STEP_UP, S_STEP_DN: begin
                        // The counter moves on this same edge, so this is its old value.
                        r_prev  <= CurrentState;
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (CurrentState != r_prev) begin
                            r_state <= S_CHECK;
                        end else if (w_timed_out) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_timer <= r_timer + 4'd1;
                        end
                    end
                    S_RECOVER: begin
                        r_timer <= '0;
                        r_state <= S_RWAIT;
                    end
                    S_RWAIT: begin
                        if (CurrentState == 4'd0) begin
                            r_state <= S_CHECK;
                        end else if (w_timed_out) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_timer <= r_timer + 4'd1;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign Up           = r_up;
    assign Down         = r_down;
    assign CounterReset = r_crst;
    assign Busy         = r_busy;
    assign Done         = r_done;
    assign Error        = r_error;
    assign Steps        = r_steps;

    a_pulse_exclusive: assert property (@(posedge clock) disable iff (!Reset)
        $onehot0({Up, Down, CounterReset}));

endmodule

// File: tb/tb_counter_seek_ctrl.sv
// Self-checking bench for counter_seek_ctrl: a behavioural mod-9 counter closes the
// loop; seeks come from a vector table, corner cases from hand-written sequences.
module tb_counter_seek_ctrl;

    logic       clock = 1'b0;
    logic       Reset;
    logic       Start;
    logic [3:0] Target;
    logic       Abort;
    logic [3:0] CurrentState;
    logic       Up;
    logic       Down;
    logic       CounterReset;
    logic       Busy;
    logic       Done;
    logic       Error;
    logic [3:0] Steps;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    counter_seek_ctrl #(.TIMEOUT(4)) dut (
        .clock        (clock),
        .Reset        (Reset),
        .Start        (Start),
        .Target       (Target),
        .Abort        (Abort),
        .CurrentState (CurrentState),
        .Up           (Up),
        .Down         (Down),
        .CounterReset (CounterReset),
        .Busy         (Busy),
        .Done         (Done),
        .Error        (Error),
        .Steps        (Steps)
    );

    // Counter model: mod-9 ring, 9..15 stick until reset; freeze ignores pulses,
    // reverse swaps the direction so a seek can never converge.
    logic [3:0] c_state  = 4'd0;
    logic       load_req = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       freeze   = 1'b0;
    logic       reverse  = 1'b0;
    logic       m_inc;
    logic       m_dec;

    assign m_inc        = reverse ? Down : Up;
    assign m_dec        = reverse ? Up : Down;
    assign CurrentState = c_state;

    always @(posedge clock) begin
        if (load_req)
            c_state <= load_val;
        else if (CounterReset)
            c_state <= 4'd0;
        else if (!freeze && (c_state <= 4'd8)) begin
            if (m_inc)
                c_state <= (c_state == 4'd8) ? 4'd0 : c_state + 4'd1;
            else if (m_dec)
                c_state <= (c_state == 4'd0) ? 4'd8 : c_state - 4'd1;
        end
    end

    int n_up = 0, n_dn = 0, n_rst = 0, n_busy = 0, n_done = 0, n_err = 0, n_excl = 0;

    always @(posedge clock) begin
        if (Up)           n_up   <= n_up + 1;
        if (Down)         n_dn   <= n_dn + 1;
        if (CounterReset) n_rst  <= n_rst + 1;
        if (Busy)         n_busy <= n_busy + 1;
        if (Done)         n_done <= n_done + 1;
        if (Error)        n_err  <= n_err + 1;
        if ((Up && Down) || (Up && CounterReset) || (Down && CounterReset))
            n_excl <= n_excl + 1;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // NOTE: inputs change 1 time unit after the rising edge and outputs are read
    // there too, well clear of the edge that samples or updates them.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_counter(input logic [3:0] v);
        load_req = 1'b1;
        load_val = v;
        step();
        load_req = 1'b0;
    endtask

    task automatic start_seek(input logic [3:0] c0, input logic [3:0] t);
        load_counter(c0);
        Target = t;
        Start  = 1'b1;
        step();
        Start  = 1'b0;
    endtask

    task automatic wait_done(output bit got, output int c_at, output int steps_at);
        got      = 1'b0;
        c_at     = -1;
        steps_at = -1;
        for (int k = 0; k < 100; k++) begin
            if (Done) begin
                got      = 1'b1;
                c_at     = int'(CurrentState);
                steps_at = int'(Steps);
                break;
            end
            step();
        end
    endtask

    typedef struct {
        int    c0;
        int    tgt;
        int    ups;
        int    dns;
        int    rsts;
        int    steps;
        string name;
    } seek_vec_t;

    seek_vec_t vecs[10];

    initial begin
        bit got;
        int c_at, steps_at, err_edge, last_steps;
        int b_up, b_dn, b_rst, b_busy, b_done, b_err;

        vecs[0] = '{2,  5, 3, 0, 0, 3, "up 2->5"};
        vecs[1] = '{1,  7, 0, 3, 0, 3, "down 1->7"};
        vecs[2] = '{4,  0, 0, 4, 0, 4, "down 4->0"};
        vecs[3] = '{0,  4, 4, 0, 0, 4, "up 0->4"};
        vecs[4] = '{8,  0, 1, 0, 0, 1, "wrap up 8->0"};
        vecs[5] = '{0,  8, 0, 1, 0, 1, "wrap down 0->8"};
        vecs[6] = '{5,  1, 0, 4, 0, 4, "down 5->1"};
        vecs[7] = '{3,  3, 0, 0, 0, 0, "at target 3"};
        vecs[8] = '{15, 3, 3, 0, 1, 3, "recover 15->3"};
        vecs[9] = '{11, 8, 0, 1, 1, 1, "recover 11->8"};

        Reset  = 1'b0;
        Start  = 1'b0;
        Abort  = 1'b0;
        Target = 4'd0;
        step();
        step();
        check("reset outputs", {Up, Down, CounterReset, Busy, Done, Error, Steps}, 0);
        Reset = 1'b1;
        step();
        check("idle after reset", {Busy, Done, Error, Steps}, 0);

        // Busy lasts 2 cycles (CHECK, DONE) plus 3 per step or recovery.
        for (int i = 0; i < 10; i++) begin
            b_up = n_up; b_dn = n_dn; b_rst = n_rst; b_busy = n_busy; b_err = n_err; b_done = n_done;
            start_seek(4'(vecs[i].c0), 4'(vecs[i].tgt));
            wait_done(got, c_at, steps_at);
            check({vecs[i].name, " done seen"}, got, 1);
            check({vecs[i].name, " state at done"}, c_at, vecs[i].tgt);
            check({vecs[i].name, " steps at done"}, steps_at, vecs[i].steps);
            step();
            step();
            step();
            check({vecs[i].name, " up pulses"}, n_up - b_up, vecs[i].ups);
            check({vecs[i].name, " down pulses"}, n_dn - b_dn, vecs[i].dns);
            check({vecs[i].name, " reset pulses"}, n_rst - b_rst, vecs[i].rsts);
            check({vecs[i].name, " busy cycles"}, n_busy - b_busy, 2 + 3 * (vecs[i].steps + vecs[i].rsts));
            check({vecs[i].name, " done count"}, n_done - b_done, 1);
            check({vecs[i].name, " no error"}, n_err - b_err, 0);
            check({vecs[i].name, " steps stable"}, Steps, vecs[i].steps);
        end
        last_steps = vecs[9].steps;

        // Invalid target: immediate Error, no seek, Steps untouched.
        b_up = n_up; b_dn = n_dn; b_rst = n_rst;
        Target = 4'd9;
        Start  = 1'b1;
        step();
        Start  = 1'b0;
        check("bad target error", Error, 1);
        check("bad target busy", Busy, 0);
        check("bad target steps", Steps, last_steps);
        step();
        check("bad target error one cycle", Error, 0);
        step();
        check("bad target no pulses", (n_up - b_up) + (n_dn - b_dn) + (n_rst - b_rst), 0);

        // Already at target: exact edge timing of Busy and Done.
        start_seek(4'd6, 4'd6);
        check("at target busy e1", Busy, 1);
        check("at target done e1", Done, 0);
        step();
        check("at target done e2", Done, 1);
        check("at target busy e2", Busy, 1);
        step();
        check("at target done e3", Done, 0);
        check("at target busy e3", Busy, 0);

        // Start while busy must not retarget the seek.
        start_seek(4'd2, 4'd5);
        Target = 4'd0;
        Start  = 1'b1;
        step();
        Start  = 1'b0;
        wait_done(got, c_at, steps_at);
        check("busy start ignored done", got, 1);
        check("busy start ignored target", c_at, 5);
        step();
        step();

        // Frozen counter: Error after TIMEOUT=4 cycles in WAIT, i.e. on edge 7.
        freeze = 1'b1;
        b_up = n_up; b_done = n_done;
        start_seek(4'd4, 4'd6);
        err_edge = -1;
        for (int k = 2; k <= 20; k++) begin
            step();
            if (Error) begin
                err_edge = k;
                break;
            end
        end
        check("timeout edge", err_edge, 7);
        check("timeout busy cleared", Busy, 0);
        step();
        check("timeout single up", n_up - b_up, 1);
        check("timeout no done", n_done - b_done, 0);
        freeze = 1'b0;

        // Abort two cycles after Start (C=0, T=6 heads down).
        b_up = n_up; b_dn = n_dn; b_done = n_done; b_err = n_err;
        start_seek(4'd0, 4'd6);
        step();
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check("abort busy cleared", Busy, 0);
        for (int k = 0; k < 6; k++) step();
        check("abort no done", n_done - b_done, 0);
        check("abort no error", n_err - b_err, 0);
        check("abort pulses at most one", ((n_up - b_up) + (n_dn - b_dn)) <= 1, 1);
        check("abort stays idle", Busy, 0);

        // Counter that moves the wrong way: seek never converges, Steps saturates.
        reverse = 1'b1;
        start_seek(4'd0, 4'd4);
        for (int k = 0; k < 70; k++) step();
        check("saturate steps", Steps, 15);
        check("saturate still busy", Busy, 1);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check("saturate abort busy", Busy, 0);
        reverse = 1'b0;

        // Asynchronous reset while waiting in WAIT.
        freeze = 1'b1;
        start_seek(4'd0, 4'd4);
        step();
        step();
        check("pre-reset busy", Busy, 1);
        check("pre-reset steps", Steps, 1);
        #2;
        Reset = 1'b0;
        #1;
        check("async reset outputs", {Up, Down, CounterReset, Busy, Done, Error, Steps}, 0);
        Reset  = 1'b1;
        freeze = 1'b0;
        step();
        step();
        check("post-reset idle", {Busy, Done, Error, Up, Down}, 0);

        check("pulse exclusivity", n_excl, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
